// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter: FSM states, owner encoding, counter sizing.
// No logic here; imported by mem_arbiter and rr_arb2.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  // Enough bits to hold MEM_LAT-1 down to zero; never narrower than one bit.
  function automatic int cnt_w(input int lat);
    return (lat < 1) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick (req[0]=I, req[1]=D), combinational one-hot grant.
// Last-grant register updates only when grant_en is high and something is granted.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic [1:0] gnt
);

  owner_t last;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      // On a tie the side that did not win last time goes first.
      2'b11:   gnt = (last == OWN_I) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last <= OWN_I;
    end else if (grant_en && (|req)) begin
      last <= gnt[1] ? OWN_D : OWN_I;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between I-cache fills and D-cache fills/writebacks; ready pulses MEM_LAT+1 cycles after a grant.
// Requesters hold req until their ready pulse; the other side waits, and its req is only sampled in IDLE.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 128,
  parameter int MEM_LAT = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ireq,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iready,
  output logic [LINE_W-1:0] irdata,
  input  logic              dreq,
  input  logic              dwe,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [LINE_W-1:0] dwdata,
  output logic              dready,
  output logic [LINE_W-1:0] drdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int            CW       = cnt_w(MEM_LAT);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t        state, state_nxt;
  owner_t        owner, owner_nxt;
  logic [CW-1:0] count, count_nxt;
  logic [1:0]    gnt;
  logic          grant_en;
  logic          last_beat;

  assign grant_en  = (state == IDLE);
  assign last_beat = (state == BUSY) && (count == '0);

  rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .reset    (reset),
    .req      ({dreq, ireq}),
    .grant_en (grant_en),
    .gnt      (gnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      owner <= OWN_I;
      count <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    count_nxt = count;
    case (state)
      IDLE: begin
        if (|gnt) begin
          owner_nxt = gnt[1] ? OWN_D : OWN_I;
          count_nxt = CNT_LOAD;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        // The zero check comes first so the counter never wraps.
        if (count == '0) begin
          state_nxt = RESP;
        end else begin
          count_nxt = count - CNT_ONE;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_req   = (state == BUSY);
    mem_we    = mem_req && (owner == OWN_D) && dwe;
    mem_addr  = '0;
    mem_wdata = '0;
    if (mem_req) begin
      mem_addr  = (owner == OWN_D) ? daddr : iaddr;
      mem_wdata = (owner == OWN_D) ? dwdata : '0;
    end
    iready = (state == RESP) && (owner == OWN_I);
    dready = (state == RESP) && (owner == OWN_D);
    busy   = (state != IDLE);
  end

  // Writebacks return nothing, so drdata keeps the last fill.
  always_ff @(posedge clk) begin
    if (reset) begin
      irdata <= '0;
      drdata <= '0;
    end else if (last_beat) begin
      if (owner == OWN_I) begin
        irdata <= mem_rdata;
      end else if (!dwe) begin
        drdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: scoreboard of expected ready pulses (port, cycle, data)
// plus per-cycle checks of the memory port; a second instance covers MEM_LAT=1.
module tb_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 128;

  logic              clk = 1'b0;
  logic              reset;
  logic              ireq, dreq, dwe;
  logic [ADDR_W-1:0] iaddr, daddr;
  logic [LINE_W-1:0] dwdata;
  logic              iready, dready;
  logic [LINE_W-1:0] irdata, drdata;
  logic              mem_req, mem_we, busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata, mem_rdata, mem_fill;
  logic              mem_model_on;

  logic              b_ireq, b_dreq, b_dwe;
  logic [ADDR_W-1:0] b_iaddr, b_daddr;
  logic [LINE_W-1:0] b_dwdata;
  logic              b_iready, b_dready;
  logic [LINE_W-1:0] b_irdata, b_drdata;
  logic              b_mem_req, b_mem_we, b_busy;
  logic [ADDR_W-1:0] b_mem_addr;
  logic [LINE_W-1:0] b_mem_wdata, b_mem_rdata;

  always #5 clk = ~clk;

  // Memory model: either a fixed fill pattern or a line derived from the address.
  assign mem_rdata = mem_model_on ? {4{~mem_addr}} : mem_fill;

  mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .MEM_LAT(5)) dut (
    .clk(clk), .reset(reset),
    .ireq(ireq), .iaddr(iaddr), .iready(iready), .irdata(irdata),
    .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata),
    .dready(dready), .drdata(drdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .MEM_LAT(1)) dut_lat1 (
    .clk(clk), .reset(reset),
    .ireq(b_ireq), .iaddr(b_iaddr), .iready(b_iready), .irdata(b_irdata),
    .dreq(b_dreq), .dwe(b_dwe), .daddr(b_daddr), .dwdata(b_dwdata),
    .dready(b_dready), .drdata(b_drdata),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  typedef struct {
    logic              port;   // 0 = I, 1 = D
    logic [LINE_W-1:0] data;
    int                cyc;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   failed = 0;
  int   total  = 0;
  int   cyc    = 0;

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Check any ready pulse of the current cycle against the scoreboard, then advance one cycle.
  task automatic adv();
    exp_t e;
    if (iready || dready) begin
      chk("ready_onehot", LINE_W'(iready & dready), '0);
      if (sb.size() == 0) begin
        chk("unexpected_ready", LINE_W'({dready, iready}), '0);
      end else begin
        e = sb.pop_front();
        chk("ready_port", LINE_W'(dready), LINE_W'(e.port));
        chk("ready_cycle", LINE_W'(cyc), LINE_W'(e.cyc));
        chk("ready_data", e.port ? drdata : irdata, e.data);
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    int guard;
    reset = 1'b1;
    ireq = 1'b0; dreq = 1'b0; dwe = 1'b0;
    iaddr = '0; daddr = '0; dwdata = '0;
    mem_fill = '0; mem_model_on = 1'b0;
    b_ireq = 1'b0; b_dreq = 1'b0; b_dwe = 1'b0;
    b_iaddr = '0; b_daddr = '0; b_dwdata = '0; b_mem_rdata = '0;
    @(negedge clk);
    adv();
    adv();
    reset = 1'b0;

    // Reset state
    chk("rst_busy", LINE_W'(busy), '0);
    chk("rst_mem_req", LINE_W'(mem_req), '0);
    chk("rst_mem_we", LINE_W'(mem_we), '0);
    chk("rst_mem_addr", LINE_W'(mem_addr), '0);
    chk("rst_ready", LINE_W'({iready, dready}), '0);
    chk("rst_irdata", irdata, '0);
    chk("rst_drdata", drdata, '0);
    chk("rst_b_busy", LINE_W'(b_busy), '0);
    adv();

    // Single I fill
    cyc = 0;
    ireq = 1'b1; iaddr = 32'h100;
    mem_fill = {16{8'hA5}};
    sb.push_back('{1'b0, {16{8'hA5}}, 6});
    for (int k = 0; k <= 6; k++) begin
      chk("t1_mem_req", LINE_W'(mem_req), LINE_W'(k >= 1 && k <= 5));
      chk("t1_busy", LINE_W'(busy), LINE_W'(k >= 1));
      if (k >= 1 && k <= 5) begin
        chk("t1_mem_addr", LINE_W'(mem_addr), LINE_W'(32'h100));
        chk("t1_mem_we", LINE_W'(mem_we), '0);
      end
      adv();
    end
    ireq = 1'b0;
    chk("t1_irdata_hold", irdata, {16{8'hA5}});
    chk("t1_idle", LINE_W'(busy), '0);
    adv();
    adv();

    // Sustained dual requests: D wins the first tie, then strict alternation
    cyc = 0;
    mem_model_on = 1'b1;
    ireq = 1'b1; iaddr = 32'h300;
    dreq = 1'b1; dwe = 1'b0; daddr = 32'h400;
    sb.push_back('{1'b1, {4{~32'h400}}, 6});
    sb.push_back('{1'b0, {4{~32'h300}}, 13});
    sb.push_back('{1'b1, {4{~32'h400}}, 20});
    sb.push_back('{1'b0, {4{~32'h300}}, 27});
    for (int k = 0; k <= 26; k++) begin
      if (k == 1 || k == 15) chk("t2_addr_d", LINE_W'(mem_addr), LINE_W'(32'h400));
      if (k == 8 || k == 22) chk("t2_addr_i", LINE_W'(mem_addr), LINE_W'(32'h300));
      adv();
    end
    ireq = 1'b0; dreq = 1'b0;
    adv();
    chk("t2_idle", LINE_W'(busy), '0);
    adv();

    // D writeback with an I request arriving mid-transaction
    cyc = 0;
    mem_model_on = 1'b0;
    mem_fill = {4{32'hC3C3_0F0F}};
    dreq = 1'b1; dwe = 1'b1; daddr = 32'h2000; dwdata = 128'h1234;
    sb.push_back('{1'b1, {4{~32'h400}}, 6});
    for (int k = 0; k <= 13; k++) begin
      if (k == 3) begin
        ireq = 1'b1; iaddr = 32'h500;
        sb.push_back('{1'b0, {4{32'hC3C3_0F0F}}, 13});
      end
      if (k == 7) begin
        dreq = 1'b0; dwe = 1'b0;
      end
      if (k >= 1 && k <= 5) begin
        chk("t3_mem_we", LINE_W'(mem_we), LINE_W'(1));
        chk("t3_mem_wdata", mem_wdata, LINE_W'(128'h1234));
        chk("t3_mem_addr", LINE_W'(mem_addr), LINE_W'(32'h2000));
      end
      if (k == 6) chk("t3_resp_no_req", LINE_W'(mem_req), '0);
      if (k == 7) chk("t3_idle_late_ireq", LINE_W'(busy), '0);
      if (k == 8) begin
        chk("t3_i_addr", LINE_W'(mem_addr), LINE_W'(32'h500));
        chk("t3_i_we", LINE_W'(mem_we), '0);
        chk("t3_i_wdata", mem_wdata, '0);
      end
      adv();
    end
    ireq = 1'b0;
    chk("t3_drdata_kept", drdata, {4{~32'h400}});
    chk("t3_irdata", irdata, {4{32'hC3C3_0F0F}});
    adv();
    adv();

    // Reset in the middle of a transaction
    cyc = 0;
    ireq = 1'b1; iaddr = 32'h600;
    for (int k = 0; k <= 3; k++) begin
      if (k == 3) begin
        reset = 1'b1;
        ireq = 1'b0;
      end
      adv();
    end
    reset = 1'b0;
    chk("t4_busy", LINE_W'(busy), '0);
    chk("t4_mem_req", LINE_W'(mem_req), '0);
    chk("t4_ready", LINE_W'({iready, dready}), '0);
    chk("t4_irdata", irdata, '0);
    chk("t4_drdata", drdata, '0);
    for (int k = 0; k < 8; k++) adv();

    // MEM_LAT = 1 instance
    cyc = 0;
    b_ireq = 1'b1; b_iaddr = 32'h40;
    b_mem_rdata = {4{32'h0BAD_F00D}};
    chk("t5_c0_mem_req", LINE_W'(b_mem_req), '0);
    adv();
    chk("t5_c1_mem_req", LINE_W'(b_mem_req), LINE_W'(1));
    chk("t5_c1_addr", LINE_W'(b_mem_addr), LINE_W'(32'h40));
    chk("t5_c1_iready", LINE_W'(b_iready), '0);
    adv();
    chk("t5_c2_mem_req", LINE_W'(b_mem_req), '0);
    chk("t5_c2_iready", LINE_W'(b_iready), LINE_W'(1));
    chk("t5_c2_irdata", b_irdata, {4{32'h0BAD_F00D}});
    adv();
    b_ireq = 1'b0;
    chk("t5_c3_iready", LINE_W'(b_iready), '0);
    chk("t5_c3_busy", LINE_W'(b_busy), '0);
    adv();

    // Every expected ready must have been consumed
    guard = 0;
    while (sb.size() != 0 && guard < 50) begin
      adv();
      guard++;
    end
    chk("sb_drain", LINE_W'(sb.size()), '0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single main-memory port between the I-cache refill path (ihit miss) and the D-cache refill/writeback path (dhit miss) of the pipelined processor. A 2-way round-robin arbiter picks one requester, a fixed-latency transaction runs against memory, and the line is returned with a one-cycle ready pulse. While a miss is outstanding, the ihit/dhit stall logic keeps the pipeline frozen.

Parameters:
ADDR_W, 32, byte address width of requests and memory port
LINE_W, 128, cache line width in bits (one transfer per transaction)
MEM_LAT, 5, memory access latency in cycles; legal range >= 1

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
ireq  input  1  I-cache line fill request; held until iready
iaddr  input  ADDR_W  I-cache line address; stable while ireq
iready  output  1  one-cycle pulse: irdata valid
irdata  output  LINE_W  registered fill data for I-cache
dreq  input  1  D-cache request; held until dready
dwe  input  1  1 = writeback (store line), 0 = fill; stable while dreq
daddr  input  ADDR_W  D-cache line address; stable while dreq
dwdata  input  LINE_W  writeback line; stable while dreq
dready  output  1  one-cycle pulse: D transaction complete
drdata  output  LINE_W  registered fill data for D-cache
mem_req  output  1  memory access active
mem_we  output  1  memory write enable
mem_addr  output  ADDR_W  memory address
mem_wdata  output  LINE_W  memory write data
mem_rdata  input  LINE_W  memory read data, valid in last BUSY cycle
busy  output  1  transaction in progress (BUSY or RESP)

Behaviour:
- Reset (sync, active-high): state=IDLE, count=0, owner=I, last=I, all outputs 0, irdata=drdata=0. Reset mid-transaction aborts it; no ready pulse is issued. The requester re-requests after reset.
- States:
  - IDLE: arbitrate.
  - BUSY: count MEM_LAT cycles.
  - RESP: pulse ready for one cycle, then go to IDLE.
- IDLE transitions:
  - Neither req -> stay in IDLE.
  - Only one req -> grant it.
  - Both reqs -> grant the requester not equal to last. Because last resets to I, the first tie goes to D.
  - On grant: latch owner, set last=owner, count=MEM_LAT-1, go to BUSY.
- BUSY:
  - mem_req=1; mem_addr/mem_we/mem_wdata driven combinationally from owner's inputs.
  - mem_we = (owner==D) & dwe; mem_wdata = dwdata when owner==D, else 0.
  - count decrements each cycle.
  - When count==0: capture mem_rdata into irdata (owner I) or drdata (owner D fill), then go to RESP.
  - D writeback does not update drdata.
- RESP:
  - Exactly one of iready/dready = 1; mem_req=0.
  - Next state is IDLE unconditionally.
- Latency: req high in IDLE cycle T gives ready high in cycle T+MEM_LAT+1. Back-to-back transactions on the same port are spaced MEM_LAT+2 cycles apart.
- Handshake rules:
  - The requester drops req the cycle after ready, so req is low in the following IDLE cycle.
  - A req that stays high after RESP is treated as a new request.
  - The non-owner's req may rise or fall freely while another transaction runs; it is only sampled in IDLE.
- Outputs irdata/drdata hold their value until the next capture for that port.
- busy = (state != IDLE).
- MEM_LAT=1: BUSY lasts exactly one cycle.
- Counter width: $clog2(MEM_LAT+1). Decrement never underflows because the count==0 exit has priority.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {IDLE, BUSY, RESP}
  - owner encoding {OWN_I=0, OWN_D=1}
  - counter width function
- Sub-module rr_arb2 contains the 2-way round-robin pick. Inputs: clk, reset, req[1:0], grant_en. Output: one-hot gnt. It owns the last-grant register.
- The main FSM, counter and data registers stay in mem_arbiter.

Test Plan:
- Single I fill, MEM_LAT=5: ireq=1, iaddr=0x100 at cycle 0, mem_rdata=0xA5..A5 -> mem_req high cycles 1-5 with mem_addr=0x100, mem_we=0; iready=1 only in cycle 6; irdata=0xA5..A5.
- Simultaneous ireq/dreq after reset -> D granted first (dready cycle 6), then I granted at cycle 7 (iready cycle 13); owner alternates I/D/I on sustained dual requests.
- D writeback: dreq=1, dwe=1, daddr=0x2000, dwdata=0x1234 -> mem_we=1 and mem_wdata=0x1234 in cycles 1-5; dready pulse cycle 6; drdata unchanged.
- Reset asserted in BUSY cycle 3 -> next cycle: state IDLE, mem_req=0, no iready/dready pulse, irdata/drdata=0.
- MEM_LAT=1 -> req at cycle 0, mem_req only in cycle 1, ready in cycle 2.
- Late arriving ireq during D BUSY -> ignored until IDLE; granted in the IDLE cycle after D's RESP.
